// File: rtl/child_fanin_collector_pkg.sv
// Shared defaults and index/counter types for the child fan-in collector.
package fanin_pkg;
    localparam int N_CHILD_DEF = 5;
    localparam int CNT_W_DEF   = 16;
    localparam int SRC_W       = $clog2(N_CHILD_DEF);

    typedef logic [SRC_W-1:0]     src_idx_t;
    typedef logic [CNT_W_DEF-1:0] grant_cnt_t;
endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter.
// The scan starts at ptr and wraps modulo N; the grant is gated by en.
module rr_arbiter_n #(
    parameter int N   = 5,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    int unsigned k;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = (32'(ptr) + i) % N;
            if (!any && req[IDX_W'(k)]) begin
                any = 1'b1;
                idx = IDX_W'(k);
            end
        end
        if (en && any) begin
            grant[idx] = 1'b1;
        end
    end
endmodule

// File: rtl/child_fanin_collector.sv
// Collects result words from N_CHILD children into one registered, source-tagged
// upstream stream with round-robin arbitration and per-child grant counters.
module child_fanin_collector
    import fanin_pkg::*;
#(
    parameter int N_CHILD = N_CHILD_DEF,
    parameter int DATA_W  = 16,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_CHILD-1:0]               child_valid,
    input  logic [N_CHILD-1:0][DATA_W-1:0]   child_data,
    output logic [N_CHILD-1:0]               child_ready,
    output logic                             up_valid,
    output logic [DATA_W-1:0]                up_data,
    output logic [$clog2(N_CHILD)-1:0]       up_src,
    input  logic                             up_ready,
    input  logic [$clog2(N_CHILD)-1:0]       cnt_sel,
    output logic [CNT_W-1:0]                 cnt_data,
    input  logic                             cnt_clr
);
    localparam int IDX_W = $clog2(N_CHILD);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] win;
    logic             any_req;
    logic             load;
    logic             take;
    logic [CNT_W-1:0] cnt [N_CHILD];

    // Gating load with rst_n keeps child_ready low during a reset cycle.
    assign load = rst_n && (!up_valid || up_ready);
    assign take = load && any_req;

    rr_arbiter_n #(
        .N     (N_CHILD),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (child_valid),
        .ptr   (rr_ptr),
        .en    (load),
        .grant (child_ready),
        .idx   (win),
        .any   (any_req)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            up_valid <= 1'b0;
            up_data  <= '0;
            up_src   <= '0;
            rr_ptr   <= '0;
            for (int unsigned i = 0; i < N_CHILD; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            if (load) begin
                if (any_req) begin
                    up_valid <= 1'b1;
                    up_data  <= child_data[win];
                    up_src   <= win;
                    rr_ptr   <= (win == IDX_W'(N_CHILD - 1)) ? '0 : win + 1'b1;
                end else begin
                    up_valid <= 1'b0;
                end
            end
            // Clear takes priority over a grant landing in the same cycle.
            for (int unsigned i = 0; i < N_CHILD; i++) begin
                if (cnt_clr) begin
                    cnt[i] <= '0;
                end else if (take && win == IDX_W'(i) && cnt[i] != '1) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        cnt_data = '0;
        if (32'(cnt_sel) < N_CHILD) begin
            cnt_data = cnt[cnt_sel];
        end
    end
endmodule

// File: tb/tb_child_fanin_collector.sv
// Randomized and directed bench for child_fanin_collector against a behavioural model.
module tb_child_fanin_collector;
    import fanin_pkg::*;

    localparam int N    = N_CHILD_DEF;
    localparam int DW   = 16;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N-1:0]            child_valid;
    logic [N-1:0][DW-1:0]    child_data;
    logic [N-1:0]            child_ready;
    logic                    up_valid;
    logic [DW-1:0]           up_data;
    src_idx_t                up_src;
    logic                    up_ready;
    src_idx_t                cnt_sel;
    logic [CW-1:0]           cnt_data;
    logic                    cnt_clr;

    child_fanin_collector #(
        .N_CHILD (N),
        .DATA_W  (DW),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .child_valid (child_valid),
        .child_data  (child_data),
        .child_ready (child_ready),
        .up_valid    (up_valid),
        .up_data     (up_data),
        .up_src      (up_src),
        .up_ready    (up_ready),
        .cnt_sel     (cnt_sel),
        .cnt_data    (cnt_data),
        .cnt_clr     (cnt_clr)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model of the upstream register, pointer and counters.
    int          m_ptr;
    int          m_src;
    logic        m_valid;
    logic [DW-1:0] m_data;
    int          m_cnt [N];
    logic        refill;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_src   = 0;
        m_valid = 1'b0;
        m_data  = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    // One clock: check at negedge, advance model at posedge, retire accepted child words.
    task automatic step();
        int          w;
        logic        load;
        logic [N-1:0] er;
        int          ecnt;
        @(negedge clk);
        w = -1;
        for (int i = 0; i < N; i++) begin
            int c;
            c = (m_ptr + i) % N;
            if (w < 0 && child_valid[c]) w = c;
        end
        load = rst_n && (!m_valid || up_ready);
        er = '0;
        if (load && w >= 0) er[w] = 1'b1;
        ecnt = 0;
        if (int'(cnt_sel) < N) ecnt = m_cnt[cnt_sel];
        check("child_ready", 32'(child_ready), 32'(er));
        check("up_valid",    32'(up_valid),    32'(m_valid));
        check("up_data",     32'(up_data),     32'(m_data));
        check("up_src",      32'(up_src),      32'(m_src));
        check("cnt_data",    32'(cnt_data),    32'(ecnt));
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (load) begin
                if (w >= 0) begin
                    m_valid  = 1'b1;
                    m_data   = child_data[w];
                    m_src    = w;
                    m_ptr    = (w + 1) % N;
                    m_cnt[w] = (m_cnt[w] < CMAX) ? m_cnt[w] + 1 : CMAX;
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (cnt_clr) for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end
        #1;
        if (rst_n && load && w >= 0) begin
            child_valid[w] = refill;
            if (refill) child_data[w] = DW'($urandom);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        child_valid = '0;
        child_data  = '0;
        up_ready    = 1'b1;
        cnt_sel     = '0;
        cnt_clr     = 1'b0;
        refill      = 1'b0;
        model_reset();
        m_valid = 1'bx;
        m_data  = 'x;
        @(posedge clk);
        #1;
        model_reset();
        step();
        rst_n = 1'b1;

        // Single source: child 2 sends A5A5, then 0 and 4 compete (pointer now at 3).
        child_valid[2] = 1'b1;
        child_data[2]  = 16'hA5A5;
        cnt_sel        = 3'd2;
        step();
        step();
        child_valid[0] = 1'b1;
        child_data[0]  = 16'h1111;
        child_valid[4] = 1'b1;
        child_data[4]  = 16'h4444;
        cnt_sel        = 3'd4;
        step();
        step();
        step();

        // All children continuously valid from reset.
        do_reset();
        refill = 1'b1;
        for (int i = 0; i < N; i++) begin
            child_valid[i] = 1'b1;
            child_data[i]  = DW'($urandom);
        end
        for (int i = 0; i < 15; i++) begin
            cnt_sel = src_idx_t'(i % N);
            step();
        end
        refill      = 1'b0;
        child_valid = '0;

        // Backpressure with children 1 and 3 waiting.
        do_reset();
        child_valid[4] = 1'b1;
        child_data[4]  = 16'hBEEF;
        up_ready       = 1'b0;
        step();
        child_valid[1] = 1'b1;
        child_data[1]  = 16'h0101;
        child_valid[3] = 1'b1;
        child_data[3]  = 16'h0303;
        for (int i = 0; i < 4; i++) step();
        up_ready = 1'b1;
        step();
        step();
        step();

        // Counter clear colliding with a grant to child 0, then an out-of-range select.
        do_reset();
        refill         = 1'b1;
        child_valid[0] = 1'b1;
        cnt_sel        = 3'd0;
        for (int i = 0; i < 7; i++) step();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        step();
        cnt_sel = 3'd6;
        step();
        child_valid = '0;

        // Saturation on child 4.
        do_reset();
        child_valid[4] = 1'b1;
        cnt_sel        = 3'd4;
        for (int i = 0; i < CMAX + 3; i++) step();
        child_valid = '0;
        refill      = 1'b0;

        // Reset while a word is held under backpressure.
        child_valid = '1;
        refill      = 1'b1;
        step();
        step();
        up_ready = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n    = 1'b1;
        up_ready = 1'b1;
        step();
        step();
        child_valid = '0;
        refill      = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!child_valid[i] && $urandom_range(0, 2) == 0) begin
                    child_valid[i] = 1'b1;
                    child_data[i]  = DW'($urandom);
                end
            end
            up_ready = ($urandom_range(0, 9) < 7);
            cnt_clr  = ($urandom_range(0, 49) == 0);
            cnt_sel  = src_idx_t'($urandom_range(0, 7));
            rst_n    = ($urandom_range(0, 99) != 0);
            step();
        end
        rst_n   = 1'b1;
        cnt_clr = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
